seven_seg_scan_receiver: RTL

//  Receiving end of the multiplexed 7-segment display interface driven by controller_alu_reg_mem_pc.

---
 rtl/seven_seg_pkg.sv | 55 +++++
 rtl/seg_glyph_decode.sv | 35 +++
 rtl/seven_seg_scan_receiver.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan receiver.
//   - Segment glyph patterns, bit0 = a .. bit6 = g, active-high (segment lit = 1).
//   - FSM state encodings for the scan tracker (IDLE / SETTLE / HOLD).
//   - Decode result struct and small helpers for the position-select bus.
package seven_seg_pkg;

  localparam int NUM_POS = 4;

  localparam logic [6:0] GLYPH_0 = 7'h3F;  // abcdef
  localparam logic [6:0] GLYPH_1 = 7'h06;  // bc
  localparam logic [6:0] GLYPH_2 = 7'h5B;  // abdeg
  localparam logic [6:0] GLYPH_3 = 7'h4F;  // abcdg
  localparam logic [6:0] GLYPH_4 = 7'h66;  // bcfg
  localparam logic [6:0] GLYPH_5 = 7'h6D;  // acdfg
  localparam logic [6:0] GLYPH_6 = 7'h7D;  // acdefg
  localparam logic [6:0] GLYPH_7 = 7'h07;  // abc
  localparam logic [6:0] GLYPH_8 = 7'h7F;  // abcdefg
  localparam logic [6:0] GLYPH_9 = 7'h6F;  // abcdfg
  localparam logic [6:0] GLYPH_A = 7'h77;  // abcefg
  localparam logic [6:0] GLYPH_B = 7'h7C;  // cdefg
  localparam logic [6:0] GLYPH_C = 7'h39;  // adef
  localparam logic [6:0] GLYPH_D = 7'h5E;  // bcdeg
  localparam logic [6:0] GLYPH_E = 7'h79;  // adefg
  localparam logic [6:0] GLYPH_F = 7'h71;  // aefg

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  typedef struct packed {
    logic       hit;
    logic [3:0] nibble;
  } glyph_dec_t;

  // Number of asserted position selects (0..4).
  function automatic logic [2:0] sel_count(input logic [NUM_POS-1:0] sel);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_POS; i++) begin
      n = n + {2'b00, sel[i]};
    end
    return n;
  endfunction

  // Index of the asserted select bit; only meaningful when exactly one is set.
  function automatic logic [1:0] sel_to_pos(input logic [NUM_POS-1:0] sel);
    logic [1:0] p;
    p = 2'd0;
    for (int i = 0; i < NUM_POS; i++) begin
      if (sel[i]) p = 2'(i);
    end
    return p;
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational segment-pattern to hex-nibble decoder.
// Ports:
//   pattern  in  7   active-high segments, bit0 = a .. bit6 = g
//   dec      out 5   {hit, nibble}; hit = 0 when the pattern is not a hex glyph
module seg_glyph_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0]  pattern,
  output glyph_dec_t  dec
);

  always_comb begin
    dec = '0;
    case (pattern)
      GLYPH_0: dec = '{hit: 1'b1, nibble: 4'h0};
      GLYPH_1: dec = '{hit: 1'b1, nibble: 4'h1};
      GLYPH_2: dec = '{hit: 1'b1, nibble: 4'h2};
      GLYPH_3: dec = '{hit: 1'b1, nibble: 4'h3};
      GLYPH_4: dec = '{hit: 1'b1, nibble: 4'h4};
      GLYPH_5: dec = '{hit: 1'b1, nibble: 4'h5};
      GLYPH_6: dec = '{hit: 1'b1, nibble: 4'h6};
      GLYPH_7: dec = '{hit: 1'b1, nibble: 4'h7};
      GLYPH_8: dec = '{hit: 1'b1, nibble: 4'h8};
      GLYPH_9: dec = '{hit: 1'b1, nibble: 4'h9};
      GLYPH_A: dec = '{hit: 1'b1, nibble: 4'hA};
      GLYPH_B: dec = '{hit: 1'b1, nibble: 4'hB};
      GLYPH_C: dec = '{hit: 1'b1, nibble: 4'hC};
      GLYPH_D: dec = '{hit: 1'b1, nibble: 4'hD};
      GLYPH_E: dec = '{hit: 1'b1, nibble: 4'hE};
      GLYPH_F: dec = '{hit: 1'b1, nibble: 4'hF};
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_receiver.sv
// Receiver for a multiplexed 4-digit seven-segment display scan.
// Rebuilds the displayed 16-bit hex word and flags malformed scans.
// Optional feature macro: SEG_DP_CAPTURE_EN (adds the dp output; otherwise digit[7] is ignored).
// Ports:
//   clk          in   1   rising-edge clock
//   reset        in   1   synchronous, active-low
//   digit        in   8   segment pattern, bit0 = a .. bit6 = g, bit7 = dp
//   segment      in   4   position select, bit i = position i (pos0 leftmost)
//   err_clr      in   1   clears sticky error flags
//   value        out  16  last complete frame, pos0 -> [15:12] .. pos3 -> [3:0]
//   frame_valid  out  1   one-cycle pulse when value updates
//   pos_valid    out  4   positions committed in the current frame
//   err_pattern  out  1   sticky: a stable pattern was not a hex glyph
//   err_select   out  1   sticky: more than one position selected
//   dp           out  4   decimal points per position (SEG_DP_CAPTURE_EN only)
module seven_seg_scan_receiver
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   digit,
  input  logic [3:0]   segment,
  input  logic         err_clr,
  output logic [15:0]  value,
  output logic         frame_valid,
  output logic [3:0]   pos_valid,
  output logic         err_pattern,
  output logic         err_select
`ifdef SEG_DP_CAPTURE_EN
  ,
  output logic [3:0]   dp
`endif
);

`ifdef SEG_DP_CAPTURE_EN
  localparam int PAT_W = 8;
`else
  localparam int PAT_W = 7;
`endif
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [PAT_W-1:0] pat_norm;
  logic [3:0]       sel_norm;

  logic [PAT_W-1:0] samp_pat_q, samp_pat_d, prev_pat_q, prev_pat_d;
  logic [3:0]       samp_sel_q, samp_sel_d, prev_sel_q, prev_sel_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_POS-1:0][3:0] shadow_q, shadow_d;
  logic [3:0]       pos_valid_q, pos_valid_d;
  logic [15:0]      value_q, value_d;
  logic             frame_valid_q, frame_valid_d;
  logic             err_pattern_q, err_pattern_d;
  logic             err_select_q, err_select_d;
`ifdef SEG_DP_CAPTURE_EN
  logic [3:0]       dp_shadow_q, dp_shadow_d;
  logic [3:0]       dp_q, dp_d;
`else
  logic             unused_dp_bit;
  assign unused_dp_bit = digit[7];
`endif

  logic             changed;
  logic             commit;
  logic [2:0]       n_sel;
  logic [1:0]       pos;
  glyph_dec_t       dec;

  // Polarity normalisation: internally everything is active-high.
  assign pat_norm = SEG_ACTIVE_LOW ? ~digit[PAT_W-1:0] : digit[PAT_W-1:0];
  assign sel_norm = SEL_ACTIVE_LOW ? ~segment : segment;

  assign n_sel   = sel_count(samp_sel_q);
  assign pos     = sel_to_pos(samp_sel_q);
  assign changed = (samp_pat_q != prev_pat_q) || (samp_sel_q != prev_sel_q);

  seg_glyph_decode u_decode (
    .pattern (samp_pat_q[6:0]),
    .dec     (dec)
  );

  always_comb begin
    samp_pat_d    = pat_norm;
    samp_sel_d    = sel_norm;
    prev_pat_d    = samp_pat_q;
    prev_sel_d    = samp_sel_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    pos_valid_d   = pos_valid_q;
    value_d       = value_q;
    frame_valid_d = 1'b0;
    err_pattern_d = err_pattern_q & ~err_clr;
    err_select_d  = err_select_q & ~err_clr;
    commit        = 1'b0;
`ifdef SEG_DP_CAPTURE_EN
    dp_shadow_d   = dp_shadow_q;
    dp_d          = dp_q;
`endif

    // Scan tracking. A fresh single-select sample starts a new stability run;
    // blanking (no select) parks in IDLE.
    if (n_sel >= 3'd2) begin
      err_select_d = 1'b1;
      state_d      = ST_IDLE;
      cnt_d        = '0;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          if (changed) begin
            if (n_sel == 3'd1) begin
              cnt_d = CNT_ONE;
              if (CNT_ONE == CNT_MAX) begin
                commit  = 1'b1;
                state_d = ST_HOLD;
              end else begin
                state_d = ST_SETTLE;
              end
            end else begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
            if (cnt_d == CNT_MAX) begin
              commit  = 1'b1;
              state_d = ST_HOLD;
            end
          end
        end
        default: begin
          // IDLE always evaluates; HOLD only once the sample moves.
          if (state_q != ST_HOLD || changed) begin
            if (n_sel == 3'd1) begin
              cnt_d = CNT_ONE;
              if (CNT_ONE == CNT_MAX) begin
                commit  = 1'b1;
                state_d = ST_HOLD;
              end else begin
                state_d = ST_SETTLE;
              end
            end else begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end
          end
        end
      endcase
    end

    // Frame publish happens the cycle after the last position commits; a
    // commit in that same cycle starts the next frame.
    if (pos_valid_q == 4'hF) begin
      value_d       = {shadow_q[0], shadow_q[1], shadow_q[2], shadow_q[3]};
      frame_valid_d = 1'b1;
      pos_valid_d   = '0;
`ifdef SEG_DP_CAPTURE_EN
      dp_d          = dp_shadow_q;
`endif
    end

    if (commit) begin
      if (dec.hit) begin
        shadow_d[pos]    = dec.nibble;
        pos_valid_d[pos] = 1'b1;
`ifdef SEG_DP_CAPTURE_EN
        dp_shadow_d[pos] = samp_pat_q[7];
`endif
      end else begin
        err_pattern_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      samp_pat_q    <= '0;
      samp_sel_q    <= '0;
      prev_pat_q    <= '0;
      prev_sel_q    <= '0;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      shadow_q      <= '0;
      pos_valid_q   <= '0;
      value_q       <= '0;
      frame_valid_q <= 1'b0;
      err_pattern_q <= 1'b0;
      err_select_q  <= 1'b0;
`ifdef SEG_DP_CAPTURE_EN
      dp_shadow_q   <= '0;
      dp_q          <= '0;
`endif
    end else begin
      samp_pat_q    <= samp_pat_d;
      samp_sel_q    <= samp_sel_d;
      prev_pat_q    <= prev_pat_d;
      prev_sel_q    <= prev_sel_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      pos_valid_q   <= pos_valid_d;
      value_q       <= value_d;
      frame_valid_q <= frame_valid_d;
      err_pattern_q <= err_pattern_d;
      err_select_q  <= err_select_d;
`ifdef SEG_DP_CAPTURE_EN
      dp_shadow_q   <= dp_shadow_d;
      dp_q          <= dp_d;
`endif
    end
  end

  assign value       = value_q;
  assign frame_valid = frame_valid_q;
  assign pos_valid   = pos_valid_q;
  assign err_pattern = err_pattern_q;
  assign err_select  = err_select_q;
`ifdef SEG_DP_CAPTURE_EN
  assign dp          = dp_q;
`endif

endmodule
